// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared widths, FSM state type and buffer entry type for the
//                instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int IFETCH_ADDR_W = 6;
    localparam int IFETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IFETCH_ADDR_W-1:0] addr;
        logic [IFETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_buffer
//  Description : Synchronous FIFO of fetch entries with flush. Flush wins over
//                push and pop in the same cycle. Head is read directly from
//                the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop   = pop && (r_count != '0);
    assign w_do_push  = push && ((r_count != (PTR_W+1)'(DEPTH)) || w_do_pop);
    assign count      = r_count;
    assign head_valid = (r_count != '0);
    assign head       = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_entry;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Owns the PC, issues word reads to instruction memory under a
//                credit check, tracks the fixed memory latency and buffers the
//                returned words for decode. Supports redirect and halt.
//                Optional macro IFETCH_PERF_CNT_EN adds saturating counters
//                perf_fetched and perf_stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W    = IFETCH_ADDR_W,
    parameter int                DATA_W    = IFETCH_DATA_W,
    parameter int                MEM_LAT   = 2,
    parameter int                BUF_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              idle
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    // Wide enough for inflight + occupancy, each bounded by BUF_DEPTH
    localparam int CNT_W = $clog2(BUF_DEPTH) + 2;

    fetch_state_e                  r_state;
    fetch_state_e                  w_state_next;
    logic [ADDR_W-1:0]             r_pc;
    logic [MEM_LAT-1:0]            r_pipe_valid;
    logic [ADDR_W-1:0]             r_pipe_addr [MEM_LAT];
    logic [CNT_W-1:0]              w_inflight;
    logic [$clog2(BUF_DEPTH):0]    w_count;
    logic                          w_head_valid;
    fetch_entry_t                  w_head;
    fetch_entry_t                  w_push_entry;
    logic                          w_pop;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next state, credit-checked issue and idle indication
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (run)  w_state_next = FETCH;
            FETCH:   if (!run) w_state_next = HALT;
            HALT:    if (run)  w_state_next = FETCH;
            default:           w_state_next = IDLE;
        endcase
        mem_req = (r_state == FETCH) && !redir_valid &&
                  ((w_inflight + CNT_W'(w_count)) < CNT_W'(BUF_DEPTH));
        idle    = (r_state != FETCH) && (w_inflight == '0) && (w_count == '0);
    end

    assign mem_addr = r_pc;

    // Program counter: redirect overrides sequential advance
    always_ff @(posedge clk) begin
        if (!reset_n)         r_pc <= RESET_PC;
        else if (redir_valid) r_pc <= redir_pc;
        else if (mem_req)     r_pc <= r_pc + ADDR_W'(1);
    end

    // In-flight pipe mirroring the memory latency; a redirect kills every entry
    always_ff @(posedge clk) begin
        if (!reset_n || redir_valid) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_pipe_addr[i] <= '0;
        end else begin
            r_pipe_valid[0] <= mem_req;
            r_pipe_addr[0]  <= r_pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end
        end
    end

    // Number of requests still waiting for their data
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) w_inflight = w_inflight + CNT_W'(r_pipe_valid[i]);
    end

    assign w_push_entry = '{addr: r_pipe_addr[MEM_LAT-1], data: mem_rdata};
    assign w_pop        = w_head_valid && inst_ready;

    ifetch_buffer #(
        .DEPTH      (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redir_valid),
        .push       (r_pipe_valid[MEM_LAT-1]),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head       (w_head)
    );

    assign inst_valid = w_head_valid;
    assign inst_data  = w_head_valid ? w_head.data : '0;
    assign inst_pc    = w_head_valid ? w_head.addr : '0;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Saturating counters; a pop discarded by a redirect is not a fetch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop && !redir_valid && (r_perf_fetched != '1))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((r_state == FETCH) && !mem_req && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit with a fixed
//                latency memory model and an issue/delivery scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int MEM_LAT   = 2;
    localparam int BUF_DEPTH = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              run;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              idle;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LAT     (MEM_LAT),
        .BUF_DEPTH   (BUF_DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .idle        (idle)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
        return 32'h0007_8000 + {26'd0, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: data for a request appears exactly MEM_LAT cycles later
    logic [MEM_LAT-1:0] req_v = '0;
    logic [ADDR_W-1:0]  req_a [MEM_LAT];
    always @(posedge clk) begin
        req_v[0] <= mem_req;
        req_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            req_v[i] <= req_v[i-1];
            req_a[i] <= req_a[i-1];
        end
    end
    assign mem_rdata = req_v[MEM_LAT-1] ? word(req_a[MEM_LAT-1]) : 32'hDEAD_BEEF;

    // Scoreboard: issued words queued in order, compared on delivery
    logic [ADDR_W+DATA_W-1:0] sb [$];
    logic [ADDR_W+DATA_W-1:0] ent;
    logic [ADDR_W-1:0]        exp_pc   = RESET_PC;
    logic                     hold_prev = 1'b0;
    logic [ADDR_W-1:0]        hold_pc;
    logic [DATA_W-1:0]        hold_data;
    logic                     halted   = 1'b0;
    logic [ADDR_W-1:0]        last_pc  = '0;
    int                       deliv_cnt = 0;
    int                       req_cnt   = 0;
    logic                     mon_en    = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n) begin
                sb.delete();
                exp_pc    = RESET_PC;
                hold_prev = 1'b0;
            end else if (redir_valid) begin
                check("redir_no_req", 64'(mem_req), 64'(0));
                sb.delete();
                exp_pc    = redir_pc;
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 64'(inst_valid), 64'(1));
                    check("hold_pc", 64'(inst_pc), 64'(hold_pc));
                    check("hold_data", 64'(inst_data), 64'(hold_data));
                end
                if (inst_valid && inst_ready) begin
                    if (sb.size() == 0) begin
                        check("inst_unexpected", 64'(inst_valid), 64'(0));
                    end else begin
                        ent = sb.pop_front();
                        check("inst_pc", 64'(inst_pc), 64'(ent[ADDR_W+DATA_W-1:DATA_W]));
                        check("inst_data", 64'(inst_data), 64'(ent[DATA_W-1:0]));
                        deliv_cnt++;
                        last_pc = inst_pc;
                    end
                end
                if (mem_req) begin
                    check("credit", 64'(sb.size() < BUF_DEPTH), 64'(1));
                    check("mem_addr", 64'(mem_addr), 64'(exp_pc));
                    if (halted) check("halt_no_req", 64'(mem_req), 64'(0));
                    sb.push_back({exp_pc, word(exp_pc)});
                    exp_pc = exp_pc + 6'd1;
                    req_cnt++;
                end
                hold_prev = inst_valid && !inst_ready;
                hold_pc   = inst_pc;
                hold_data = inst_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next delivery and compare its pc
    task automatic expect_next(input string tag, input logic [ADDR_W-1:0] pc);
        int d0;
        d0 = deliv_cnt;
        for (int i = 0; i < 40 && deliv_cnt == d0; i++) tick();
        check({tag, "_seen"}, 64'(deliv_cnt > d0), 64'(1));
        check(tag, 64'(last_pc), 64'(pc));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic redirect(input logic [ADDR_W-1:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        tick();
        redir_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_req, c_val, d0, r0;
        logic [ADDR_W-1:0] resume_pc;
        reset_n = 1'b0; run = 1'b0; redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b0;
        mon_en = 1'b1;
        tick(); tick(); tick();
        check("rst_inst_valid", 64'(inst_valid), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));

        // 1: streaming from reset
        reset_n = 1'b1; run = 1'b1; inst_ready = 1'b1;
        c_req = -1; c_val = -1;
        for (int i = 0; i < 40 && c_val < 0; i++) begin
            tick();
            if (mem_req && c_req < 0) c_req = i;
            if (inst_valid && c_val < 0) begin
                c_val = i;
                check("first_pc", 64'(inst_pc), 64'(0));
                check("first_data", 64'(inst_data), 64'h0007_8000);
            end
        end
        check("first_latency", 64'(c_val - c_req), 64'(MEM_LAT + 1));
        d0 = deliv_cnt;
        repeat (10) tick();
        check("throughput", 64'(deliv_cnt - d0), 64'(10));

        // 2: decode stalled from reset
        inst_ready = 1'b0;
        do_reset();
        r0 = req_cnt;
        repeat (10) tick();
        check("stall_req_cnt", 64'(req_cnt - r0), 64'(BUF_DEPTH));
        check("stall_outstanding", 64'(sb.size()), 64'(BUF_DEPTH));
        check("stall_mem_req", 64'(mem_req), 64'(0));
        check("stall_head_pc", 64'(inst_pc), 64'(0));
        inst_ready = 1'b1;
        d0 = deliv_cnt;
        repeat (20) tick();
        check("resume_deliv", 64'(deliv_cnt - d0 >= 15), 64'(1));

        // 3: redirect with words buffered and in flight
        inst_ready = 1'b0;
        tick(); tick();
        inst_ready = 1'b1;
        redirect(6'd40);
        check("redir_inst_valid", 64'(inst_valid), 64'(0));
        check("redir_req", 64'(mem_req), 64'(1));
        check("redir_addr", 64'(mem_addr), 64'(40));
        expect_next("redir_pc0", 6'd40);
        expect_next("redir_pc1", 6'd41);

        // 4: pc wrap
        redirect(6'd62);
        expect_next("wrap0", 6'd62);
        expect_next("wrap1", 6'd63);
        expect_next("wrap2", 6'd0);
        expect_next("wrap3", 6'd1);

        // 5: halt drains, then resume; redirect during halt
        run = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) tick();
        check("halt_idle", 64'(idle), 64'(1));
        check("halt_drained", 64'(sb.size()), 64'(0));
        check("halt_inst_valid", 64'(inst_valid), 64'(0));
        halted = 1'b1;
        repeat (5) tick();
        resume_pc = exp_pc;
        halted = 1'b0; run = 1'b1;
        expect_next("halt_resume", resume_pc);
        run = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) tick();
        halted = 1'b1;
        redirect(6'd10);
        check("halt_redir_idle", 64'(idle), 64'(1));
        check("halt_redir_req", 64'(mem_req), 64'(0));
        tick();
        halted = 1'b0; run = 1'b1;
        expect_next("halt_redir_pc", 6'd10);

        // 6: reset mid-stream
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rst_inst_valid", 64'(inst_valid), 64'(0));
        check("mid_rst_idle", 64'(idle), 64'(1));
        check("mid_rst_mem_req", 64'(mem_req), 64'(0));
`ifdef IFETCH_PERF_CNT_EN
        check("mid_rst_perf_fetched", 64'(perf_fetched), 64'(0));
        check("mid_rst_perf_stall", 64'(perf_stall), 64'(0));
`endif
        d0 = deliv_cnt;
        expect_next("mid_rst_pc", RESET_PC);
`ifdef IFETCH_PERF_CNT_EN
        repeat (3) tick();
        check("perf_fetched", 64'(perf_fetched), 64'(deliv_cnt - d0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
